// File: rtl/intt_pair_seq_pkg.sv
// FHE_ALU_PKG: shared sizes, FSM state type, control-word layout and the
// butterfly pair-index helper for the INTT pair sequencer.
//   logN / N / FSIZE   : transform size and coefficient width
//   MEM_RD_CYCLES      : fixed latency of coefficient and twiddle memories
//   IBUTTER_CYCLES     : butterfly pipeline depth (write-back delay)
package FHE_ALU_PKG;

    localparam int logN           = 4;
    localparam int N              = 1 << logN;
    localparam int FSIZE          = 32;
    localparam int MEM_RD_CYCLES  = 2;
    localparam int IBUTTER_CYCLES = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        SCALE,
        FLUSH
    } intt_state_t;

    typedef struct packed {
        logic [logN-1:0] x;
        logic [logN-1:0] y;
        logic [logN-1:0] root_idx;
    } pair_idx_t;

    // Control word carried alongside each read so it lines up with the data.
    // kind: 0 idle, 1 butterfly, 2 scale. sel_y picks the y read port in SCALE.
    typedef struct packed {
        logic [1:0]      kind;
        logic            skip;
        logic            sel_y;
        logic [logN-1:0] level;
        logic [logN-1:0] x;
        logic [logN-1:0] y;
        logic [logN-1:0] root_idx;
    } ctl_t;

    // Pair k of level L: gap = 2^L, group = k / gap, offset = k mod gap.
    function automatic pair_idx_t calc_pair_idx(input logic [logN-1:0] lvl,
                                                input logic [logN-1:0] k);
        pair_idx_t       p;
        logic [logN-1:0] gap;
        logic [logN-1:0] grp;
        logic [logN-1:0] off;
        gap        = logN'(1) << lvl;
        grp        = k >> lvl;
        off        = k & (gap - logN'(1));
        p.x        = (grp << (lvl + logN'(1))) + off;
        p.y        = p.x + gap;
        p.root_idx = logN'(N >> (lvl + logN'(1))) + grp;
        return p;
    endfunction

endpackage

// File: rtl/FifoBuffer.sv
// FifoBuffer: fixed-depth delay line. out_data is in_data delayed by DEPTH
// clock cycles. Asynchronous active-low reset clears every stage.
//   clk, rstn : clock and async active-low reset
//   in_data   : word entering the line
//   out_data  : word leaving the line (registered)
module FifoBuffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign out_data = stage[DEPTH-1];

endmodule

// File: rtl/intt_pair_idx.sv
// intt_pair_idx: combinational butterfly index generator.
//   lvl, k            : current level and pair number within the level
//   x, y, root_idx    : coefficient addresses and twiddle index of the pair
module intt_pair_idx
    import FHE_ALU_PKG::*;
(
    input  logic [logN-1:0] lvl,
    input  logic [logN-1:0] k,
    output logic [logN-1:0] x,
    output logic [logN-1:0] y,
    output logic [logN-1:0] root_idx
);

    pair_idx_t p;

    assign p        = calc_pair_idx(lvl, k);
    assign x        = p.x;
    assign y        = p.y;
    assign root_idx = p.root_idx;

endmodule

// File: rtl/intt_pair_seq.sv
// intt_pair_seq: sequences the butterfly pairs of an N-point inverse NTT,
// one pair per cycle per level, then an optional N^-1 scaling pass.
//   start, skip_mask, n_inv, n_inv_q : run control and scaling constants
//   wb_valid                         : one pulse per pair written back
//   rd_en, rd_addr_x/y, tw_addr      : memory read request
//   rd_data_x/y, tw_W, tw_WQ         : read data, RD_CYCLES after rd_en
//   a, b, W, WQ, in_valid, skip_level, NTT_level, x, y, root_idx
//                                    : butterfly operands, RD_CYCLES+1 after rd_en
//   busy, done                       : run in progress / completion pulse
module intt_pair_seq
    import FHE_ALU_PKG::*;
#(
    parameter int SCALE_EN  = 1,
    parameter int RD_CYCLES = MEM_RD_CYCLES
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [logN-1:0]  skip_mask,
    input  logic [FSIZE-1:0] n_inv,
    input  logic [FSIZE-1:0] n_inv_q,
    input  logic             wb_valid,
    output logic             rd_en,
    output logic [logN-1:0]  rd_addr_x,
    output logic [logN-1:0]  rd_addr_y,
    output logic [logN-1:0]  tw_addr,
    input  logic [FSIZE-1:0] rd_data_x,
    input  logic [FSIZE-1:0] rd_data_y,
    input  logic [FSIZE-1:0] tw_W,
    input  logic [FSIZE-1:0] tw_WQ,
    output logic [FSIZE-1:0] a,
    output logic [FSIZE-1:0] b,
    output logic [FSIZE-1:0] W,
    output logic [FSIZE-1:0] WQ,
    output logic [1:0]       in_valid,
    output logic             skip_level,
    output logic [logN-1:0]  NTT_level,
    output logic [logN-1:0]  x,
    output logic [logN-1:0]  y,
    output logic [logN-1:0]  root_idx,
    output logic             busy,
    output logic             done
);

    localparam logic [logN-1:0] LAST_K   = logN'(N / 2 - 1);
    localparam logic [logN-1:0] LAST_LVL = logN'(logN - 1);

    intt_state_t     state;
    logic [logN-1:0] lvl;
    logic [logN-1:0] k;
    logic [logN-1:0] outstanding;
    logic            issue;
    logic [logN-1:0] px, py, pr;
    ctl_t            ctl_in;
    ctl_t            ctl_out;
    logic [2:0]      sel_pipe [RD_CYCLES];
    logic [1:0]      kind_at_data;
    logic            sel_y_at_data;

    intt_pair_idx u_idx (
        .lvl      (lvl),
        .k        (k),
        .x        (px),
        .y        (py),
        .root_idx (pr)
    );

    assign issue     = (state == ISSUE) || (state == SCALE);
    assign rd_en     = issue;
    assign rd_addr_x = issue ? px : '0;
    assign rd_addr_y = issue ? py : '0;
    // Scaling needs no twiddle; the address is parked at zero.
    assign tw_addr   = (state == ISSUE) ? pr : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            lvl         <= '0;
            k           <= '0;
            outstanding <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            // An issue and a write-back in the same cycle cancel out.
            case ({issue, wb_valid})
                2'b10:   outstanding <= outstanding + logN'(1);
                2'b01:   outstanding <= outstanding - logN'(1);
                default: outstanding <= outstanding;
            endcase
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= ISSUE;
                        lvl         <= '0;
                        k           <= '0;
                        outstanding <= '0;
                        busy        <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (k == LAST_K) begin
                        k     <= '0;
                        state <= DRAIN;
                    end else begin
                        k <= k + logN'(1);
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        if (lvl < LAST_LVL) begin
                            lvl   <= lvl + logN'(1);
                            state <= ISSUE;
                        end else begin
                            state <= (SCALE_EN != 0) ? SCALE : FLUSH;
                        end
                    end
                end
                SCALE: begin
                    if (k == LAST_K) begin
                        k     <= '0;
                        state <= FLUSH;
                    end else begin
                        k <= k + logN'(1);
                    end
                end
                FLUSH: begin
                    if (outstanding == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Never more pairs in flight than one level holds.
    assert property (@(posedge clk) disable iff (!rstn) outstanding <= logN'(N / 2));

    always_comb begin
        ctl_in = '0;
        if (state == ISSUE) begin
            ctl_in.kind     = 2'd1;
            ctl_in.skip     = skip_mask[lvl];
            ctl_in.level    = lvl;
            ctl_in.x        = px;
            ctl_in.y        = py;
            ctl_in.root_idx = pr;
        end else if (state == SCALE) begin
            ctl_in.kind  = 2'd2;
            ctl_in.sel_y = k[0];
            ctl_in.level = lvl;
            ctl_in.x     = px;
            ctl_in.y     = py;
        end
    end

    // Issue stage -> output stage: control rides RD_CYCLES+1 registers.
    FifoBuffer #(
        .WIDTH ($bits(ctl_t)),
        .DEPTH (RD_CYCLES + 1)
    ) u_ctl_dly (
        .clk      (clk),
        .rstn     (rstn),
        .in_data  (ctl_in),
        .out_data (ctl_out)
    );

    // Issue stage -> read-data stage: operand selection must be known the
    // cycle the memory data is valid, one cycle ahead of the outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < RD_CYCLES; i++) sel_pipe[i] <= '0;
        end else begin
            sel_pipe[0] <= {ctl_in.kind, ctl_in.sel_y};
            for (int i = 1; i < RD_CYCLES; i++) sel_pipe[i] <= sel_pipe[i-1];
        end
    end

    assign {kind_at_data, sel_y_at_data} = sel_pipe[RD_CYCLES-1];

    // Read-data stage -> output stage: operands hold when nothing arrives.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a  <= '0;
            b  <= '0;
            W  <= '0;
            WQ <= '0;
        end else if (kind_at_data == 2'd1) begin
            a  <= rd_data_x;
            b  <= rd_data_y;
            W  <= tw_W;
            WQ <= tw_WQ;
        end else if (kind_at_data == 2'd2) begin
            a  <= sel_y_at_data ? rd_data_y : rd_data_x;
            b  <= '0;
            W  <= n_inv;
            WQ <= n_inv_q;
        end
    end

    assign in_valid   = ctl_out.kind;
    assign skip_level = ctl_out.skip;
    assign NTT_level  = ctl_out.level;
    assign x          = ctl_out.x;
    assign y          = ctl_out.y;
    assign root_idx   = ctl_out.root_idx;

endmodule

// File: tb/tb_intt_pair_seq.sv
// tb_intt_pair_seq: randomized self-checking bench for intt_pair_seq.
// The reference model enumerates each level's butterflies as groups of
// 2*gap coefficients and reads a random memory image to predict operands.
module tb_intt_pair_seq;
    import FHE_ALU_PKG::*;

    localparam int RD   = MEM_RD_CYCLES;
    localparam int D    = IBUTTER_CYCLES;
    localparam int HALF = N / 2;

    logic             clk, rstn, start, wb_valid, rd_en;
    logic [logN-1:0]  skip_mask, rd_addr_x, rd_addr_y, tw_addr;
    logic [FSIZE-1:0] n_inv, n_inv_q, rd_data_x, rd_data_y, tw_W, tw_WQ;
    logic [FSIZE-1:0] a, b, W, WQ;
    logic [1:0]       in_valid;
    logic             skip_level, busy, done;
    logic [logN-1:0]  NTT_level, x, y, root_idx;

    intt_pair_seq #(.SCALE_EN(1), .RD_CYCLES(RD)) dut (
        .clk(clk), .rstn(rstn), .start(start), .skip_mask(skip_mask),
        .n_inv(n_inv), .n_inv_q(n_inv_q), .wb_valid(wb_valid),
        .rd_en(rd_en), .rd_addr_x(rd_addr_x), .rd_addr_y(rd_addr_y),
        .tw_addr(tw_addr), .rd_data_x(rd_data_x), .rd_data_y(rd_data_y),
        .tw_W(tw_W), .tw_WQ(tw_WQ), .a(a), .b(b), .W(W), .WQ(WQ),
        .in_valid(in_valid), .skip_level(skip_level), .NTT_level(NTT_level),
        .x(x), .y(y), .root_idx(root_idx), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int kind; int x; int y; int root; int level; int skip;
        logic [FSIZE-1:0] a; logic [FSIZE-1:0] b;
        logic [FSIZE-1:0] w; logic [FSIZE-1:0] wq;
    } exp_t;

    exp_t exp_q[$];
    int   out_due_q[$];
    int   wb_due_q[$];
    int   n_checks = 0, n_fail = 0, cyc = 0;
    int   iss_idx, out_idx, done_cnt, done_cyc, start_cyc, last_wb_cyc, gap_l1;
    int   n_scale_out, n_skip_out;
    int   obs_x[64], obs_y[64], obs_root[64];
    logic hold;
    logic [FSIZE-1:0] last_a, last_w;
    logic [FSIZE-1:0] coef[N], tw[N], twq[N];
    logic pv[RD+1];
    int   pax[RD+1], pay[RD+1], pat[RD+1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic build_exp(input logic [logN-1:0] mask, input logic [FSIZE-1:0] ninv,
                             input logic [FSIZE-1:0] ninvq);
        exp_t e;
        exp_q.delete();
        for (int l = 0; l < logN; l++) begin
            int gap = 1 << l;
            for (int grp = 0; grp < N / (2 * gap); grp++) begin
                for (int off = 0; off < gap; off++) begin
                    e.kind  = 1;
                    e.x     = grp * 2 * gap + off;
                    e.y     = e.x + gap;
                    e.root  = N / (2 * gap) + grp;
                    e.level = l;
                    e.skip  = int'(mask[l]);
                    e.a = coef[e.x]; e.b = coef[e.y];
                    e.w = tw[e.root]; e.wq = twq[e.root];
                    exp_q.push_back(e);
                end
            end
        end
        for (int j = 0; j < HALF; j++) begin
            e.kind = 2; e.x = j; e.y = j + HALF; e.root = 0;
            e.level = logN - 1; e.skip = 0;
            e.a = (j % 2 == 1) ? coef[j + HALF] : coef[j];
            e.b = '0; e.w = ninv; e.wq = ninvq;
            exp_q.push_back(e);
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   want_kind;
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (rd_en === 1'b1) begin
            if (iss_idx < exp_q.size()) begin
                e = exp_q[iss_idx];
                chk("iss_addr_x", rd_addr_x, e.x);
                chk("iss_addr_y", rd_addr_y, e.y);
                if (e.kind == 1) chk("iss_tw_addr", tw_addr, e.root);
                if (iss_idx < 64) begin
                    obs_x[iss_idx] = rd_addr_x; obs_y[iss_idx] = rd_addr_y;
                    obs_root[iss_idx] = tw_addr;
                end
                out_due_q.push_back(cyc + RD + 1);
            end else begin
                chk("extra_issue", iss_idx, exp_q.size());
            end
            if (iss_idx == HALF) gap_l1 = cyc - last_wb_cyc;
            iss_idx++;
        end
        want_kind = 0;
        if (out_due_q.size() > 0 && out_due_q[0] == cyc) want_kind = exp_q[out_idx].kind;
        chk("in_valid", in_valid, want_kind);
        if (want_kind != 0) begin
            void'(out_due_q.pop_front());
            e = exp_q[out_idx];
            chk("out_skip", skip_level, e.skip);
            chk("out_level", NTT_level, e.level);
            chk("out_x", x, e.x);
            chk("out_y", y, e.y);
            chk("out_root", root_idx, e.root);
            chk("out_a", a, e.a);
            chk("out_b", b, e.b);
            chk("out_w", W, e.w);
            chk("out_wq", WQ, e.wq);
            last_a = e.a; last_w = e.w;
            if (skip_level === 1'b1) n_skip_out++;
            if (in_valid == 2'd2) n_scale_out++;
            wb_due_q.push_back(cyc + D);
            out_idx++;
        end else begin
            chk("hold_a", a, last_a);
            chk("hold_w", W, last_w);
        end
        for (int i = RD; i > 0; i--) begin
            pv[i] = pv[i-1]; pax[i] = pax[i-1]; pay[i] = pay[i-1]; pat[i] = pat[i-1];
        end
        pv[0] = rd_en; pax[0] = rd_addr_x; pay[0] = rd_addr_y; pat[0] = tw_addr;
        rd_data_x = pv[RD] ? coef[pax[RD]] : $urandom();
        rd_data_y = pv[RD] ? coef[pay[RD]] : $urandom();
        tw_W      = pv[RD] ? tw[pat[RD]]   : $urandom();
        tw_WQ     = pv[RD] ? twq[pat[RD]]  : $urandom();
        if (!hold && wb_due_q.size() > 0 && wb_due_q[0] <= cyc) begin
            wb_valid = 1'b1;
            void'(wb_due_q.pop_front());
            last_wb_cyc = cyc;
        end else begin
            wb_valid = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic reset_model();
        exp_q.delete(); out_due_q.delete(); wb_due_q.delete();
        for (int i = 0; i <= RD; i++) begin pv[i] = 1'b0; pax[i] = 0; pay[i] = 0; pat[i] = 0; end
        iss_idx = 0; out_idx = 0; done_cnt = 0; last_a = '0; last_w = '0;
        hold = 1'b0; wb_valid = 1'b0; start = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_outputs", |{rd_en, rd_addr_x, rd_addr_y, tw_addr, a, b, W, WQ, in_valid,
                             skip_level, NTT_level, x, y, root_idx, busy, done}, 0);
        repeat (3) @(negedge clk);
        reset_model();
        rstn = 1'b1;
    endtask

    task automatic prep(input logic [logN-1:0] mask, input logic [FSIZE-1:0] ninv);
        for (int i = 0; i < N; i++) begin
            coef[i] = $urandom(); tw[i] = $urandom(); twq[i] = $urandom();
        end
        skip_mask = mask;
        n_inv     = ninv;
        n_inv_q   = $urandom();
        build_exp(mask, ninv, n_inv_q);
        out_due_q.delete(); wb_due_q.delete();
        iss_idx = 0; out_idx = 0; done_cnt = 0; last_wb_cyc = 0; gap_l1 = -1;
        n_scale_out = 0; n_skip_out = 0;
    endtask

    task automatic launch();
        start = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
        chk("start_issue", rd_en, 1);
        chk("busy_on", busy, 1);
    endtask

    task automatic finish_run(input int check_len);
        int t = 0;
        int want_len, diff;
        while (done_cnt == 0 && t < 2000) begin step(); t++; end
        if (done_cnt == 0) chk("done_timeout", 0, 1);
        repeat (8) step();
        chk("done_once", done_cnt, 1);
        chk("busy_after", busy, 0);
        chk("issues", iss_idx, exp_q.size());
        chk("outputs", out_idx, exp_q.size());
        if (check_len != 0) begin
            want_len = logN * (HALF + RD + 1 + D) + (HALF + RD + 1 + D) + 1;
            diff = done_cyc - start_cyc - want_len;
            chk("run_len", (diff >= -(logN + 1) && diff <= logN + 1), 1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        rstn = 1'b0; start = 1'b0; wb_valid = 1'b0; hold = 1'b0;
        skip_mask = '0; n_inv = '0; n_inv_q = '0;
        rd_data_x = '0; rd_data_y = '0; tw_W = '0; tw_WQ = '0;
        #2;
        do_reset();

        // Plain run, scaling constant 0x1234, a stray start mid-run.
        prep(4'b0000, 32'h1234);
        launch();
        repeat (10) step();
        start = 1'b1;
        step();
        start = 1'b0;
        finish_run(1);
        chk("l0_first_x", obs_x[0], 0);
        chk("l0_first_y", obs_y[0], 1);
        chk("l0_first_root", obs_root[0], 8);
        chk("l0_last_x", obs_x[7], 14);
        chk("l0_last_root", obs_root[7], 15);
        chk("l3_first_y", obs_y[24], 8);
        chk("l3_first_root", obs_root[24], 1);
        chk("l3_last_x", obs_x[31], 7);
        chk("l3_last_root", obs_root[31], 1);
        chk("scale_outputs", n_scale_out, HALF);

        // Level 2 forwarded unmodified.
        prep(4'b0100, $urandom());
        launch();
        finish_run(1);
        chk("skip_outputs", n_skip_out, HALF);

        // Write-backs withheld for 50 cycles after level 0 is issued.
        prep(4'($urandom_range(0, 15)), $urandom());
        launch();
        t = 0;
        while (iss_idx < HALF && t < 100) begin step(); t++; end
        hold = 1'b1;
        repeat (50) begin
            step();
            chk("hold_no_issue", rd_en, 0);
        end
        hold = 1'b0;
        finish_run(0);
        // Counter reaches zero the cycle after the last pulse; the next
        // level issues one cycle after that.
        chk("drain_restart", gap_l1, 2);

        // Reset at pair 5 of level 1.
        prep(4'($urandom_range(0, 15)), $urandom());
        launch();
        t = 0;
        while (iss_idx < HALF + 6 && t < 200) begin step(); t++; end
        chk("abort_point", iss_idx, HALF + 6);
        do_reset();
        repeat (20) step();
        chk("no_done_abort", done_cnt, 0);
        chk("idle_after_abort", busy, 0);
        prep(4'b0000, $urandom());
        launch();
        finish_run(1);

        // Random masks and constants.
        repeat (3) begin
            prep(4'($urandom_range(0, 15)), $urandom());
            launch();
            finish_run(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
